memory_writeback: RTL
=====================

# memory_writeback

Pipeline stage that consumes the Execute-stage registered results (ALU result, PC, instruction, store data) and performs the data-memory access over a variable-latency request/response handshake. It drives byte-masked stores, aligns and sign-extends load data, and produces the registered writeback bundle (enable, rd, data, instruction) for the register file. It asserts `Stall` to freeze upstream pipeline registers while an access is outstanding, and inserts a bubble into writeback while stalled.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `ALU_out_reg` in 32: ALU result / effective address of the Memory-stage instruction.
- `PC_addr_Execute` in 32: PC of the Memory-stage instruction.
- `Inst_Execute` in 32: Memory-stage instruction.
- `Store_Data` in 32: rs2 value of the Memory-stage instruction.
- `Mem_req` out 1: access request.
- `Mem_addr` out 32: word address, `{ALU_out_reg[31:2], 2'b00}`.
- `Mem_we` out 4: byte write mask; `0000` for loads.
- `Mem_wdata` out 32: lane-replicated store data.
- `Mem_ready` in 1: memory accepts the request in this cycle.
- `Mem_rvalid` in 1: load response valid.
- `Mem_rdata` in 32: load response word.
- `Stall` out 1: hold all upstream pipeline registers this cycle.
- `RegWEn` out reg 1: register-file write enable.
- `Rd` out reg 5: destination register.
- `Data_WB` out reg 32: writeback data.
- `Inst_Memory` out reg 32: instruction in the Writeback stage.

## Operation
- Decode: opcode `Inst_Execute[6:0]`; LOAD `0000011`, STORE `0100011`; funct3 `Inst_Execute[14:12]`; offset `ALU_out_reg[1:0]`.
- FSM states:
  - IDLE
    - Memory op present: `Mem_req=1`.
    - `Mem_ready=1` with a store: access complete; remain in IDLE.
    - `Mem_ready=1` with a load: go to WAIT.
    - `Mem_ready=0`: remain in IDLE with the request held. Inputs stay stable because upstream is stalled.
  - WAIT
    - `Mem_req=0`.
    - `Mem_rvalid=1`: load complete; return to IDLE.
    - `Mem_rvalid` in IDLE is ignored.
- `Stall` (combinational) = memory op present AND access not completing this cycle.
  - Non-memory ops never stall.
  - A store accepted in its first cycle never stalls.
  - A load stalls at least 1 cycle.
- Store mask and data:
  - SB: `0001 << off`, wdata `{4{rs2[7:0]}}`.
  - SH: `0011 << {off[1],0}`, wdata `{2{rs2[15:0]}}`.
  - SW: `1111`, wdata `rs2`.
  - Other funct3: mask `0000`; the handshake still runs.
- Load extraction from `Mem_rdata`:
  - LB/LBU: byte at `off`, sign- or zero-extended.
  - LH/LHU: half at `off[1]`, sign- or zero-extended.
  - LW, and any other funct3: full word.
- Writeback register update, every cycle with `Stall=0`:
  - `Inst_Memory<=Inst_Execute`, `Rd<=Inst_Execute[11:7]`.
  - `RegWEn<=1` for LUI, AUIPC, JAL, JALR, OP, OP-IMM and LOAD when rd≠0; otherwise 0.
  - `Data_WB` = extracted load data for LOAD, `PC_addr_Execute+4` (mod 2^32) for JAL/JALR, else `ALU_out_reg`.
- Writeback update with `Stall=1` (bubble): `RegWEn<=0`, `Inst_Memory<=32'h00000013`. `Rd` and `Data_WB` hold.

## Timing
- Reset values:
  - Outputs: `RegWEn=0`, `Rd=0`, `Data_WB=0`, `Inst_Memory=32'h00000013`.
  - FSM: IDLE.
  - Combinational outputs follow from the inputs while in IDLE.
- Store: request and completion in the same cycle when `Mem_ready=1`.
- Load: accepted in cycle N; `Mem_rvalid` no earlier than N+1. `Data_WB` is valid on the edge ending the `Mem_rvalid` cycle.
- `Mem_addr`, `Mem_we` and `Mem_wdata` stay stable while `Mem_req=1 && Mem_ready=0`.
- One outstanding load maximum. Back-to-back memory ops are issued on consecutive cycles when no stall occurs.
- Reset in WAIT: return to IDLE; any later `Mem_rvalid` for the abandoned load is ignored and produces no writeback.
- Reset overrides a simultaneous `Mem_rvalid` or `Mem_ready`.

## Test plan
- Reset: hold `rst` one cycle → `RegWEn=0`, `Data_WB=0`, `Inst_Memory=0x00000013`, `Stall=0`, `Mem_req=0` with a non-memory instruction.
- SB to `0x1003`, rs2=`0x000000AB`, `Mem_ready=1` → `Mem_req=1`, `Mem_addr=0x1000`, `Mem_we=1000`, `Mem_wdata=0xABABABAB`, `Stall=0`; next edge `RegWEn=0`.
- SW with `Mem_ready=0` for 2 cycles, then 1 → `Stall=1` for 2 cycles and `Mem_addr`/`Mem_wdata` constant; `Stall=0` in the accept cycle; two bubbles with `Inst_Memory=0x13`.
- LH rd=x5 from `0x2002`, accepted in cycle 0, `Mem_rvalid` in cycle 3 with `Mem_rdata=0x80011234` → `Stall=1` in cycles 0–2, `Stall=0` in cycle 3. After that edge: `RegWEn=1`, `Rd=5`, `Data_WB=0xFFFF8001`. LHU under the same conditions → `Data_WB=0x00008001`.
- JAL rd=x1 at PC `0x100` → `Data_WB=0x104`, `RegWEn=1`. ADD with rd=x0 → `RegWEn=0`.
- Load accepted, `rst` in WAIT, `Mem_rvalid=1` two cycles after reset → FSM in IDLE, `RegWEn` stays 0, `Stall` follows the current instruction only.

Source files
------------

// File: rtl/memory_writeback.sv
// memory_writeback: memory access over a req/ready/rvalid handshake plus registered writeback bundle
module memory_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_out_reg,
  input  logic [31:0] PC_addr_Execute,
  input  logic [31:0] Inst_Execute,
  input  logic [31:0] Store_Data,
  output logic        Mem_req,
  output logic [31:0] Mem_addr,
  output logic [3:0]  Mem_we,
  output logic [31:0] Mem_wdata,
  input  logic        Mem_ready,
  input  logic        Mem_rvalid,
  input  logic [31:0] Mem_rdata,
  output logic        Stall,
  output logic        RegWEn,
  output logic [4:0]  Rd,
  output logic [31:0] Data_WB,
  output logic [31:0] Inst_Memory
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic regwen_q, regwen_d;
  logic [4:0] rd_q, rd_d;
  logic [31:0] data_wb_q, data_wb_d, inst_mem_q, inst_mem_d;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [1:0] off;
  logic is_load, is_store, wb_en, is_jump;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  assign opc = Inst_Execute[6:0];
  assign f3 = Inst_Execute[14:12];
  assign off = ALU_out_reg[1:0];
  assign is_load = opc == 7'b0000011;
  assign is_store = opc == 7'b0100011;
  assign is_jump = opc == 7'b1101111 || opc == 7'b1100111;
  assign wb_en = Inst_Execute[11:7] != 5'd0 && (is_load || is_jump || opc == 7'b0110111 ||
                 opc == 7'b0010111 || opc == 7'b0110011 || opc == 7'b0010011);
  assign Mem_req = state_q == IDLE && (is_load || is_store);
  assign Mem_addr = {ALU_out_reg[31:2], 2'b00};
  assign RegWEn = regwen_q;
  assign Rd = rd_q;
  assign Data_WB = data_wb_q;
  assign Inst_Memory = inst_mem_q;
  always_comb begin
    Mem_we = !is_store ? 4'b0000 :
             f3 == 3'b000 ? 4'b0001 << off :
             f3 == 3'b001 ? 4'b0011 << {off[1], 1'b0} :
             f3 == 3'b010 ? 4'b1111 : 4'b0000;
    Mem_wdata = f3 == 3'b000 ? {4{Store_Data[7:0]}} :
                f3 == 3'b001 ? {2{Store_Data[15:0]}} : Store_Data;
    ld_byte = Mem_rdata[{off, 3'b000} +: 8];
    ld_half = off[1] ? Mem_rdata[31:16] : Mem_rdata[15:0];
    ld_data = f3 == 3'b000 ? {{24{ld_byte[7]}}, ld_byte} :
              f3 == 3'b100 ? {24'd0, ld_byte} :
              f3 == 3'b001 ? {{16{ld_half[15]}}, ld_half} :
              f3 == 3'b101 ? {16'd0, ld_half} : Mem_rdata;
    // In WAIT the load is still presented because upstream is frozen
    Stall = state_q == WAIT ? !Mem_rvalid : (is_load || (is_store && !Mem_ready));
    state_d = state_q == WAIT ? (Mem_rvalid ? IDLE : WAIT) :
              (is_load && Mem_ready ? WAIT : IDLE);
    regwen_d = Stall ? 1'b0 : wb_en;
    inst_mem_d = Stall ? 32'h00000013 : Inst_Execute;
    rd_d = Stall ? rd_q : Inst_Execute[11:7];
    data_wb_d = Stall ? data_wb_q : is_load ? ld_data :
                is_jump ? PC_addr_Execute + 32'd4 : ALU_out_reg;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      regwen_q <= 1'b0;
      rd_q <= 5'd0;
      data_wb_q <= 32'd0;
      inst_mem_q <= 32'h00000013;
    end else begin
      state_q <= state_d;
      regwen_q <= regwen_d;
      rd_q <= rd_d;
      data_wb_q <= data_wb_d;
      inst_mem_q <= inst_mem_d;
    end
  end
endmodule
